// File: rtl/i2c_pkg.sv
// Shared state encoding and protocol constants for the I2C register target.
// Latency: none; types and constants only.
// Backpressure: none.
package i2c_pkg;

  // Wide enough to count 0..8 (eight data bits plus the ACK slot marker).
  localparam int BIT_CNT_W = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchronizer, FILTER_LEN hold filter, edge/START/STOP pulses.
// Latency: 2 sync cycles + FILTER_LEN filter cycles from pin change to pulse.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
module i2c_line_cond #(
  parameter int FILTER_LEN = 3
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]    w_raw;
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_filt;
  logic [1:0]    r_filt_d;
  logic [CW-1:0] r_cnt [2];

  assign w_raw = {i_sda, i_scl};

  // Synchronize each line, then only accept a new level after it has held for FILTER_LEN cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_meta   <= 2'b11;
      r_sync   <= 2'b11;
      r_filt   <= 2'b11;
      r_filt_d <= 2'b11;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_meta   <= w_raw;
      r_sync   <= r_meta;
      r_filt_d <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_filt[i] <= r_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_scl       = r_filt[0];
  assign o_sda       = r_filt[1];
  assign o_scl_rise  =  r_filt[0] & ~r_filt_d[0];
  assign o_scl_fall  = ~r_filt[0] &  r_filt_d[0];
  // START/STOP require SCL high on both sides of the SDA transition.
  assign o_start_det =  r_filt_d[1] & ~r_filt[1] & r_filt[0] & r_filt_d[0];
  assign o_stop_det  = ~r_filt_d[1] &  r_filt[1] & r_filt[0] & r_filt_d[0];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target turning START/addr/pointer/data/STOP into register-file strobes; reads need I2C_SLAVE_READ_EN.
// Latency: reg_wr one cycle after the filtered 8th SCL rise; SDA changes the cycle after a filtered SCL fall.
// Backpressure: none toward the bus (SCL never stretched); reg_rdata must be valid 2 cycles after reg_rd.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h1A,
  parameter int         FILTER_LEN = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       addr_hit
);

  logic w_scl_f, w_sda_f, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_line_cond (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .i_scl       (scl),
    .i_sda       (sda),
    .o_scl       (w_scl_f),
    .o_sda       (w_sda_f),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop)
  );

  i2c_state_t           r_state;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_sda_oe;
  logic [7:0]           r_reg_addr;
  logic [7:0]           r_reg_wdata;
  logic                 r_reg_wr;
  logic                 r_busy;
  logic                 r_addr_hit;
`ifdef I2C_SLAVE_READ_EN
  logic                 r_rw;
  logic                 r_reg_rd;
  logic [1:0]           r_rd_pipe;
`endif

  logic [7:0] w_byte;
  logic       w_last_bit;
  logic       w_ack_start;
  logic       w_ack_end;

  assign w_byte      = {r_shift[6:0], w_sda_f};
  assign w_last_bit  = (r_bit_cnt == BIT_CNT_W'(7));
  // First SCL fall after the 8th bit opens the ACK slot; the next fall closes it.
  assign w_ack_start = w_scl_fall && (r_bit_cnt == BIT_CNT_W'(8));
  assign w_ack_end   = w_scl_fall && (r_bit_cnt != BIT_CNT_W'(8));

  // Protocol FSM: bit shifting, ACK/data driving and register-file strobes; START/STOP beat SCL edges.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_sda_oe    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wr    <= 1'b0;
      r_busy      <= 1'b0;
      r_addr_hit  <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      r_rw        <= I2C_WR;
      r_reg_rd    <= 1'b0;
      r_rd_pipe   <= '0;
`endif
    end else begin
      r_reg_wr   <= 1'b0;
      r_addr_hit <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      r_reg_rd   <= 1'b0;
      r_rd_pipe  <= {r_rd_pipe[0], r_reg_rd};
`endif
      if (w_stop) begin
        r_state   <= IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                if (w_byte[7:1] != SLAVE_ADDR) begin
                  r_state <= IGNORE;
`ifndef I2C_SLAVE_READ_EN
                end else if (w_byte[0] == I2C_RD) begin
                  r_state <= IGNORE;
`endif
                end else begin
                  r_state    <= ADDR_ACK;
                  r_addr_hit <= 1'b1;
                  r_busy     <= 1'b1;
`ifdef I2C_SLAVE_READ_EN
                  r_rw       <= w_byte[0];
`endif
                end
              end
            end
          end
          PTR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                r_reg_addr <= w_byte;
                r_state    <= PTR_ACK;
              end
            end
          end
          WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                r_reg_wdata <= w_byte;
                r_reg_wr    <= 1'b1;
                r_state     <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (w_ack_start) begin
              r_sda_oe  <= 1'b1;
              r_bit_cnt <= '0;
            end else if (w_ack_end) begin
`ifdef I2C_SLAVE_READ_EN
              if (r_rw == I2C_RD) begin
                r_state  <= RDATA;
                r_sda_oe <= ~r_shift[7];
              end else
`endif
              begin
                r_state  <= PTR;
                r_sda_oe <= 1'b0;
              end
            end
`ifdef I2C_SLAVE_READ_EN
            if (w_scl_rise && r_rw == I2C_RD) r_reg_rd <= 1'b1;
`endif
          end
          PTR_ACK: begin
            if (w_ack_start) begin
              r_sda_oe  <= 1'b1;
              r_bit_cnt <= '0;
            end else if (w_ack_end) begin
              r_sda_oe <= 1'b0;
              r_state  <= WDATA;
            end
          end
          WDATA_ACK: begin
            if (w_ack_start) begin
              r_sda_oe  <= 1'b1;
              r_bit_cnt <= '0;
            end else if (w_ack_end) begin
              r_sda_oe   <= 1'b0;
              r_state    <= WDATA;
              r_reg_addr <= r_reg_addr + 1'b1;
            end
          end
`ifdef I2C_SLAVE_READ_EN
          RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == BIT_CNT_W'(8)) begin
                r_sda_oe  <= 1'b0;
                r_state   <= RDATA_ACK;
                r_bit_cnt <= '0;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          RDATA_ACK: begin
            if (w_scl_rise) begin
              if (w_sda_f == I2C_NACK) begin
                r_state <= IGNORE;
              end else begin
                r_reg_addr <= r_reg_addr + 1'b1;
                r_reg_rd   <= 1'b1;
              end
            end else if (w_scl_fall) begin
              r_state  <= RDATA;
              r_sda_oe <= ~r_shift[7];
            end
          end
`endif
          default: ;
        endcase
      end
`ifdef I2C_SLAVE_READ_EN
      // Read data arrives two cycles after the strobe and becomes the next byte to shift out.
      if (r_rd_pipe[1]) r_shift <= reg_rdata;
`endif
    end
  end

  // Open-drain: only ever pull low or release.
  assign sda       = r_sda_oe ? I2C_ACK : 1'bz;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign reg_wr    = r_reg_wr;
  assign busy      = r_busy;
  assign addr_hit  = r_addr_hit;

`ifdef I2C_SLAVE_READ_EN
  assign reg_rd = r_reg_rd;
  logic w_unused;
  assign w_unused = w_scl_f;
`else
  assign reg_rd = 1'b0;
  logic w_unused;
  assign w_unused = ^{w_scl_f, reg_rdata, r_shift[7]};
`endif

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged master, register-bank model, strobe monitor.
// Latency: SCL quarter period Q sys_clk cycles, well above the conditioning delay.
// Backpressure: none; the bench never stretches SCL.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int Q = 10;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       scl       = 1'b1;
  logic       m_sda_oe  = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy, addr_hit;

  int n_chk = 0;
  int n_err = 0;
  int hit_cnt = 0;
  int rd_cnt = 0;
  int drove_cnt = 0;
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];

  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda);

  // Register bank model: each location reads back as its address inverted.
  assign reg_rdata = reg_addr ^ 8'hFF;

  always #5 sys_clk = ~sys_clk;

  i2c_slave_regs dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .scl       (scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .addr_hit  (addr_hit)
  );

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge sys_clk) begin
    if (reg_wr) begin
      wa_q.push_back(reg_addr);
      wd_q.push_back(reg_wdata);
    end
    if (addr_hit) hit_cnt++;
    if (reg_rd) rd_cnt++;
    if (sda === 1'b0 && m_sda_oe == 1'b0) drove_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout, required finish before 2ms");
    $fatal(1, "simulation timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
    if (idx < wa_q.size()) begin
      check({tag, "_addr"}, wa_q[idx], a);
      check({tag, "_data"}, wd_q[idx], d);
    end
  endtask

  task automatic send_bit(input logic b);
    m_sda_oe = ~b; tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_oe = 1'b0; tick(Q); scl = 1'b1; tick(Q); b = sda; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_sda_oe = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_sda_oe = 1'b0; tick(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(mack);
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] d, input logic exp_ack);
    logic a;
    write_byte(d, a);
    check(tag, {7'd0, a}, {7'd0, exp_ack});
  endtask

  initial begin
    int wb, hb, db, rb0;
    logic [7:0] rb;
    logic [7:0] c;

    // Reset values while reset is held.
    tick(5);
    check("rst_sda", {7'd0, sda}, 8'h01);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_wr", {7'd0, reg_wr}, 8'h00);
    check("rst_reg_rd", {7'd0, reg_rd}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_addr_hit", {7'd0, addr_hit}, 8'h00);
    sys_rst_n = 1'b1;
    tick(20);

    // Two-byte write at pointer 0x05 with auto-increment.
    wb = wa_q.size(); hb = hit_cnt;
    i2c_start();
    wr_chk("t1_addr_ack", 8'h34, 1'b0);
    check("t1_hit", 8'(hit_cnt - hb), 8'h01);
    check("t1_busy", {7'd0, busy}, 8'h01);
    wr_chk("t1_ptr_ack", 8'h05, 1'b0);
    wr_chk("t1_d0_ack", 8'hA7, 1'b0);
    wr_chk("t1_d1_ack", 8'h3C, 1'b0);
    check("t1_busy_pre_stop", {7'd0, busy}, 8'h01);
    i2c_stop();
    check("t1_busy_post_stop", {7'd0, busy}, 8'h00);
    check("t1_nwr", 8'(wa_q.size() - wb), 8'h02);
    check_wr("t1_w0", wb, 8'h05, 8'hA7);
    check_wr("t1_w1", wb + 1, 8'h06, 8'h3C);
    check("t1_ptr_after", reg_addr, 8'h07);

    // Wrong address: never ACKed, no strobes.
    wb = wa_q.size(); hb = hit_cnt; db = drove_cnt;
    i2c_start();
    wr_chk("t2_addr_nack", 8'h36, 1'b1);
    wr_chk("t2_ptr_nack", 8'h05, 1'b1);
    i2c_stop();
    check("t2_nwr", 8'(wa_q.size() - wb), 8'h00);
    check("t2_hit", 8'(hit_cnt - hb), 8'h00);
    check("t2_sda_driven", 8'(drove_cnt - db), 8'h00);
    check("t2_busy", {7'd0, busy}, 8'h00);

    // Pointer wrap 0xFF -> 0x00.
    wb = wa_q.size();
    i2c_start();
    wr_chk("t3_addr_ack", 8'h34, 1'b0);
    wr_chk("t3_ptr_ack", 8'hFE, 1'b0);
    wr_chk("t3_d0_ack", 8'h11, 1'b0);
    wr_chk("t3_d1_ack", 8'h22, 1'b0);
    wr_chk("t3_d2_ack", 8'h33, 1'b0);
    i2c_stop();
    check("t3_nwr", 8'(wa_q.size() - wb), 8'h03);
    check_wr("t3_w0", wb, 8'hFE, 8'h11);
    check_wr("t3_w1", wb + 1, 8'hFF, 8'h22);
    check_wr("t3_w2", wb + 2, 8'h00, 8'h33);
    check("t3_ptr_after", reg_addr, 8'h01);

`ifdef I2C_SLAVE_READ_EN
    // Pointer write, repeated START, three-byte read ending in NACK.
    wb = wa_q.size(); rb0 = rd_cnt;
    i2c_start();
    wr_chk("t4_addr_ack", 8'h34, 1'b0);
    wr_chk("t4_ptr_ack", 8'h10, 1'b0);
    i2c_start();
    wr_chk("t4_raddr_ack", 8'h35, 1'b0);
    read_byte(rb, 1'b0);
    check("t4_rd0", rb, 8'hEF);
    read_byte(rb, 1'b0);
    check("t4_rd1", rb, 8'hEE);
    read_byte(rb, 1'b1);
    check("t4_rd2", rb, 8'hED);
    check("t4_sda_released", {7'd0, sda}, 8'h01);
    i2c_stop();
    check("t4_nrd", 8'(rd_cnt - rb0), 8'h03);
    check("t4_nwr", 8'(wa_q.size() - wb), 8'h00);
    check("t4_ptr_after", reg_addr, 8'h12);
`else
    // Read request without read support: NACKed, no read strobe.
    hb = hit_cnt; rb0 = rd_cnt;
    i2c_start();
    wr_chk("t4_raddr_nack", 8'h35, 1'b1);
    i2c_stop();
    check("t4_nrd", 8'(rd_cnt - rb0), 8'h00);
    check("t4_hit", 8'(hit_cnt - hb), 8'h00);
`endif

    // Reset asserted while the target drives an address ACK.
    c = 8'h34;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    m_sda_oe = 1'b0; tick(Q); scl = 1'b1; tick(3);
    check("t5_ack_driven", {7'd0, sda}, 8'h00);
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_sda", {7'd0, sda}, 8'h01);
    check("t5_rst_busy", {7'd0, busy}, 8'h00);
    check("t5_rst_ptr", reg_addr, 8'h00);
    tick(3);
    sys_rst_n = 1'b1;
    tick(20);
    wb = wa_q.size();
    i2c_start();
    wr_chk("t5_addr_ack", 8'h34, 1'b0);
    wr_chk("t5_ptr_ack", 8'h40, 1'b0);
    wr_chk("t5_d0_ack", 8'h5A, 1'b0);
    i2c_stop();
    check("t5_nwr", 8'(wa_q.size() - wb), 8'h01);
    check_wr("t5_w0", wb, 8'h40, 8'h5A);

    // Two-cycle SDA glitch while SCL is high must be filtered out.
    wb = wa_q.size(); hb = hit_cnt;
    c = 8'h81;
    i2c_start();
    wr_chk("t6_addr_ack", 8'h34, 1'b0);
    m_sda_oe = 1'b0; tick(Q); scl = 1'b1; tick(Q / 2);
    m_sda_oe = 1'b1; tick(2); m_sda_oe = 1'b0;
    tick(2 * Q - Q / 2 - 2); scl = 1'b0; tick(Q);
    for (int i = 6; i >= 0; i--) send_bit(c[i]);
    begin
      logic a;
      recv_bit(a);
      check("t6_ptr_ack", {7'd0, a}, 8'h00);
    end
    check("t6_busy_mid", {7'd0, busy}, 8'h01);
    wr_chk("t6_d0_ack", 8'h99, 1'b0);
    i2c_stop();
    check("t6_hit", 8'(hit_cnt - hb), 8'h01);
    check("t6_nwr", 8'(wa_q.size() - wb), 8'h01);
    check_wr("t6_w0", wb, 8'h81, 8'h99);
    check("t6_busy_post", {7'd0, busy}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
